// File: rtl/cache_params_pkg.sv
// Shared parameters for the instruction-cache memory side.
//
// Holds the address/beat geometry used by the fill responder and its
// request queue. It also holds the fill FSM state encoding, so the
// responder and anything that watches its debug state port agree on it.
package cache_params_pkg;

    localparam int ADDR_WIDTH     = 16;
    localparam int MEM_IF_WIDTH   = 128;
    localparam int OFFSET_BITS    = 4;
    localparam int WORD_WIDTH     = 20;
    // 16 words x 20 bits = 320 bits, carried as three 128-bit beats
    localparam int BEATS_PER_LINE = 3;

    localparam int LINE_BITS       = ADDR_WIDTH - OFFSET_BITS;
    localparam int LINE_COUNT      = 1 << LINE_BITS;
    localparam int BEAT_BITS       = 2;
    localparam int LOAD_ADDR_WIDTH = LINE_BITS + BEAT_BITS;
    // Wide enough for the largest legal latency (15)
    localparam int CNT_BITS        = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } fill_state_t;

endpackage

// File: rtl/sync_req_fifo.sv
// Small synchronous request queue.
//
// Ports:
//   clk, arst        clock, asynchronous active-high reset (empties the queue)
//   hold             freezes the queue: no push and no pop while high
//   push, push_data  write strobe and entry
//   pop              read strobe; head advances at the edge
//   head             oldest entry (valid when !empty)
//   full, empty      occupancy flags, registered
//
// A push and a pop in the same cycle are allowed at any occupancy. At full
// the pop frees the slot that the push then fills.
module sync_req_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             hold,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    slots [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                do_push;
    logic                do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = slots[rd_ptr];

    assign do_pop  = pop & ~empty & ~hold;
    assign do_push = push & (~full | do_pop) & ~hold;

    function automatic logic [PTR_BITS-1:0] ptr_next(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Entry storage carries no reset; the pointers and count define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imem_fill_responder.sv
// Backing-memory responder for instruction-cache line fills.
//
// A line-fill request is accepted on the memory request port. The line is
// returned LATENCY cycles later as BEATS_PER_LINE consecutive beats. A
// preload port writes the line storage at any time, including while halted.
//
// Ports:
//   clk, arst          clock, asynchronous active-high reset
//   i_halt             freezes FSM, counter, beat index and queue; beats held back
//   i_mem_addr         request address; only [ADDR_WIDTH-1:OFFSET_BITS] used
//   i_mem_req_valid    request strobe
//   o_mem_req_ready    request can be accepted this cycle
//   o_mem_data         beat data (registered)
//   o_mem_data_valid   beat valid (registered), no backpressure
//   o_mem_beat_last    final beat of a line (registered)
//   i_load_addr        preload index {line, beat}; beat >= BEATS_PER_LINE dropped
//   i_load_data        preload data
//   i_load_valid       preload write strobe
//   o_fsm_state        current fill FSM state, for observation
//
// Handshake: a request transfers on a rising edge where i_mem_req_valid and
// o_mem_req_ready are both high. Ready depends only on the registered queue
// flags and i_halt, never on valid. The data port has no ready: each beat
// is presented for exactly one cycle with o_mem_data_valid high.
module imem_fill_responder
    import cache_params_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int REQ_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       i_halt,
    input  logic [MEM_IF_WIDTH-1:0]    i_mem_addr,
    input  logic                       i_mem_req_valid,
    output logic                       o_mem_req_ready,
    output logic [MEM_IF_WIDTH-1:0]    o_mem_data,
    output logic                       o_mem_data_valid,
    output logic                       o_mem_beat_last,
    input  logic [LOAD_ADDR_WIDTH-1:0] i_load_addr,
    input  logic [MEM_IF_WIDTH-1:0]    i_load_data,
    input  logic                       i_load_valid,
    output fill_state_t                o_fsm_state
);

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS_PER_LINE - 1);
    localparam logic [CNT_BITS-1:0]  WAIT_LOAD = CNT_BITS'(LATENCY - 2);

    // ------------------------------------------------------------------
    // Line storage: synchronous read, read-first against preload writes
    // ------------------------------------------------------------------
    logic [MEM_IF_WIDTH-1:0] mem [LINE_COUNT][BEATS_PER_LINE];

    logic [LINE_BITS-1:0] ld_line;
    logic [BEAT_BITS-1:0] ld_beat;

    assign ld_line = i_load_addr[LOAD_ADDR_WIDTH-1:BEAT_BITS];
    assign ld_beat = i_load_addr[BEAT_BITS-1:0];

    always_ff @(posedge clk) begin
        if (i_load_valid && (ld_beat < BEAT_BITS'(BEATS_PER_LINE))) begin
            mem[ld_line][ld_beat] <= i_load_data;
        end
    end

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    logic                 ready_en_q;
    logic                 q_push;
    logic                 q_pop;
    logic                 q_full;
    logic                 q_empty;
    logic [LINE_BITS-1:0] q_head;
    logic [LINE_BITS-1:0] req_line;
    logic                 unused_addr_bits;

    // Fills are line-aligned, so the offset and upper bus bits are ignored
    assign req_line         = i_mem_addr[ADDR_WIDTH-1:OFFSET_BITS];
    assign unused_addr_bits = ^{i_mem_addr[MEM_IF_WIDTH-1:ADDR_WIDTH],
                                i_mem_addr[OFFSET_BITS-1:0]};

    // ready_en_q keeps ready low throughout reset and comes up on the first edge after it
    assign o_mem_req_ready = ready_en_q & ~q_full & ~i_halt;
    assign q_push          = i_mem_req_valid & o_mem_req_ready;

    sync_req_fifo #(
        .WIDTH (LINE_BITS),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .arst      (arst),
        .hold      (i_halt),
        .push      (q_push),
        .push_data (req_line),
        .pop       (q_pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    // ------------------------------------------------------------------
    // Fill FSM
    // ------------------------------------------------------------------
    fill_state_t          state_q,  state_d;
    logic [CNT_BITS-1:0]  cnt_q,    cnt_d;
    logic [BEAT_BITS-1:0] beat_q,   beat_d;
    logic [LINE_BITS-1:0] line_q,   line_d;
    logic                 rd_en;
    logic [BEAT_BITS-1:0] rd_beat;
    logic                 valid_d;
    logic                 last_d;

    assign o_fsm_state = state_q;

    // In BURST, beat_q is the beat currently on the output. The read for the
    // next beat is issued while the current one is shown. The state is left
    // one cycle after the final beat, which produces the LATENCY-1 idle gap
    // between queued lines.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        line_d  = line_q;
        q_pop   = 1'b0;
        rd_en   = 1'b0;
        rd_beat = beat_q;
        valid_d = 1'b0;
        last_d  = 1'b0;

        if (!i_halt) begin
            case (state_q)
                IDLE: begin
                    if (!q_empty) begin
                        q_pop   = 1'b1;
                        line_d  = q_head;
                        cnt_d   = WAIT_LOAD;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = BURST;
                        beat_d  = '0;
                        rd_en   = 1'b1;
                        rd_beat = '0;
                        valid_d = 1'b1;
                        last_d  = (LAST_BEAT == '0);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                BURST: begin
                    if (beat_q == LAST_BEAT) begin
                        if (!q_empty) begin
                            q_pop   = 1'b1;
                            line_d  = q_head;
                            cnt_d   = WAIT_LOAD;
                            state_d = WAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rd_en   = 1'b1;
                        rd_beat = beat_q + 1'b1;
                        beat_d  = beat_q + 1'b1;
                        valid_d = 1'b1;
                        last_d  = ((beat_q + 1'b1) == LAST_BEAT);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            beat_q           <= '0;
            line_q           <= '0;
            o_mem_data       <= '0;
            o_mem_data_valid <= 1'b0;
            o_mem_beat_last  <= 1'b0;
            ready_en_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            beat_q           <= beat_d;
            line_q           <= line_d;
            o_mem_data_valid <= valid_d;
            o_mem_beat_last  <= last_d;
            ready_en_q       <= 1'b1;
            // The storage read lands directly in the output register
            if (rd_en) begin
                o_mem_data <= mem[line_q][rd_beat];
            end
        end
    end

endmodule

// File: tb/tb_imem_fill_responder.sv
module tb_imem_fill_responder;
    import cache_params_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic                       clk = 1'b0;
    logic                       arst = 1'b0;
    logic                       i_halt = 1'b0;
    logic [MEM_IF_WIDTH-1:0]    i_mem_addr = '0;
    logic                       i_mem_req_valid = 1'b0;
    logic                       o_mem_req_ready;
    logic [MEM_IF_WIDTH-1:0]    o_mem_data;
    logic                       o_mem_data_valid;
    logic                       o_mem_beat_last;
    logic [LOAD_ADDR_WIDTH-1:0] i_load_addr = '0;
    logic [MEM_IF_WIDTH-1:0]    i_load_data = '0;
    logic                       i_load_valid = 1'b0;
    fill_state_t                o_fsm_state;

    always #5 clk = ~clk;

    imem_fill_responder #(
        .LATENCY   (4),
        .REQ_DEPTH (2)
    ) dut (
        .clk              (clk),
        .arst             (arst),
        .i_halt           (i_halt),
        .i_mem_addr       (i_mem_addr),
        .i_mem_req_valid  (i_mem_req_valid),
        .o_mem_req_ready  (o_mem_req_ready),
        .o_mem_data       (o_mem_data),
        .o_mem_data_valid (o_mem_data_valid),
        .o_mem_beat_last  (o_mem_beat_last),
        .i_load_addr      (i_load_addr),
        .i_load_data      (i_load_data),
        .i_load_valid     (i_load_valid),
        .o_fsm_state      (o_fsm_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [MEM_IF_WIDTH-1:0] exp_q[$];
    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    localparam logic [127:0] D11  = {16{8'h11}};
    localparam logic [127:0] D22  = {16{8'h22}};
    localparam logic [127:0] D33  = {16{8'h33}};
    localparam logic [127:0] DAA  = {16{8'hAA}};
    localparam logic [127:0] DBAD = {16{8'hDE}};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Distinct content per {line, beat}
    function automatic logic [127:0] pat(input logic [11:0] line, input logic [1:0] beat);
        return {8{2'b00, beat, line}};
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [11:0] line, input logic [1:0] beat, input logic [127:0] d);
        i_load_addr  = {line, beat};
        i_load_data  = d;
        i_load_valid = 1'b1;
        step();
        i_load_valid = 1'b0;
    endtask

    task automatic request(input logic [15:0] addr, input string tag);
        i_mem_addr      = {112'h0, addr};
        i_mem_req_valid = 1'b1;
        chk({tag, "_ready"}, o_mem_req_ready, 1'b1);
        step();
        i_mem_req_valid = 1'b0;
    endtask

    task automatic expect_line(input logic [11:0] line);
        for (int b = 0; b < 3; b++) exp_q.push_back(pat(line, 2'(b)));
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            step();
            chk({tag, "_novalid"}, o_mem_data_valid, 1'b0);
        end
    endtask

    task automatic beat(input string tag, input logic last);
        logic [127:0] e;
        e = exp_q.pop_front();
        chk({tag, "_valid"}, o_mem_data_valid, 1'b1);
        chk({tag, "_data"}, o_mem_data, e);
        chk({tag, "_last"}, o_mem_beat_last, last);
    endtask

    task automatic burst(input string tag);
        for (int b = 0; b < 3; b++) begin
            step();
            beat(tag, b == 2);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        // Reset values
        #2 arst = 1'b1;
        #20;
        chk("rst_ready", o_mem_req_ready, 1'b0);
        chk("rst_valid", o_mem_data_valid, 1'b0);
        chk("rst_data", o_mem_data, '0);
        chk("rst_last", o_mem_beat_last, 1'b0);
        chk("rst_state", o_fsm_state, IDLE);
        @(negedge clk) arst = 1'b0;
        step();
        chk("post_rst_ready", o_mem_req_ready, 1'b1);

        // Preload
        load(12'h03A, 2'd0, D11);
        load(12'h03A, 2'd1, D22);
        load(12'h03A, 2'd2, D33);
        for (int b = 0; b < 3; b++) begin
            load(12'h010, 2'(b), pat(12'h010, 2'(b)));
            load(12'h020, 2'(b), pat(12'h020, 2'(b)));
            load(12'h030, 2'(b), pat(12'h030, 2'(b)));
            load(12'h03B, 2'(b), pat(12'h03B, 2'(b)));
        end
        // Beat index 3 is out of range and must not land anywhere
        load(12'h03A, 2'd3, DBAD);

        // Single fill: beats LATENCY cycles after acceptance
        exp_q.push_back(D11);
        exp_q.push_back(D22);
        exp_q.push_back(D33);
        request(16'h03A7, "single");
        idle(1, "single_w1");
        chk("single_state_wait", o_fsm_state, WAIT);
        idle(2, "single_w2");
        burst("single");
        idle(1, "single_end");
        chk("single_state_idle", o_fsm_state, IDLE);

        // Queue full: three back-to-back requests, bursts 3 idle cycles apart
        expect_line(12'h010);
        expect_line(12'h020);
        expect_line(12'h030);
        request(16'h0100, "qf_a");
        request(16'h0200, "qf_b");
        request(16'h0300, "qf_c");
        chk("qf_ready_low", o_mem_req_ready, 1'b0);
        idle(1, "qf_wait_a");
        burst("qf_a");
        chk("qf_ready_held", o_mem_req_ready, 1'b0);
        step();
        chk("qf_gap1_novalid", o_mem_data_valid, 1'b0);
        chk("qf_ready_back", o_mem_req_ready, 1'b1);
        idle(2, "qf_gap1");
        burst("qf_b");
        idle(3, "qf_gap2");
        burst("qf_c");
        idle(1, "qf_end");
        chk("qf_state_idle", o_fsm_state, IDLE);

        // Dropped out-of-range preload left the neighbouring line intact
        expect_line(12'h03B);
        request(16'h03B0, "drop");
        idle(3, "drop_wait");
        burst("drop");
        idle(1, "drop_end");

        // Halt right after beat 0 for 5 cycles
        expect_line(12'h010);
        request(16'h0100, "halt");
        idle(3, "halt_wait");
        step();
        beat("halt_b0", 1'b0);
        i_halt = 1'b1;
        #1;
        chk("halt_ready", o_mem_req_ready, 1'b0);
        repeat (5) begin
            step();
            chk("halt_novalid", o_mem_data_valid, 1'b0);
            chk("halt_nolast", o_mem_beat_last, 1'b0);
        end
        i_halt = 1'b0;
        step();
        beat("halt_b1", 1'b0);
        step();
        beat("halt_b2", 1'b1);
        idle(1, "halt_end");
        chk("halt_state_idle", o_fsm_state, IDLE);

        // Preload collision with the beat-1 read returns the old data
        exp_q.push_back(D11);
        exp_q.push_back(D22);
        exp_q.push_back(D33);
        request(16'h03A0, "coll");
        idle(3, "coll_wait");
        step();
        beat("coll_b0", 1'b0);
        i_load_addr  = {12'h03A, 2'd1};
        i_load_data  = DAA;
        i_load_valid = 1'b1;
        step();
        i_load_valid = 1'b0;
        beat("coll_b1_old", 1'b0);
        step();
        beat("coll_b2", 1'b1);
        idle(1, "coll_end");
        exp_q.push_back(D11);
        exp_q.push_back(DAA);
        exp_q.push_back(D33);
        request(16'h03A0, "coll_rep");
        idle(3, "coll_rep_wait");
        burst("coll_rep");
        idle(1, "coll_rep_end");

        // Reset mid-burst with one request still queued
        exp_q.push_back(pat(12'h010, 2'd0));
        request(16'h0100, "rmb_a");
        request(16'h0200, "rmb_b");
        chk("rmb_b_novalid", o_mem_data_valid, 1'b0);
        idle(2, "rmb_wait");
        step();
        beat("rmb_b0", 1'b0);
        arst = 1'b1;
        #1;
        chk("rmb_valid", o_mem_data_valid, 1'b0);
        chk("rmb_data", o_mem_data, '0);
        chk("rmb_last", o_mem_beat_last, 1'b0);
        chk("rmb_ready", o_mem_req_ready, 1'b0);
        chk("rmb_state", o_fsm_state, IDLE);
        step();
        step();
        arst = 1'b0;
        step();
        chk("rmb_ready_after", o_mem_req_ready, 1'b1);
        idle(12, "rmb_after");
        chk("rmb_state_after", o_fsm_state, IDLE);

        chk("exp_q_drained", 128'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
